id_ex_issue_buffer: RTL and testbench
=====================================

Name: id_ex_issue_buffer

Overview:
- Parametrised elastic buffer between the ID and EX stages. It carries the ID-to-EX bus payload and generalises the single-entry stage register to a DEPTH-entry FIFO.
- Uses the codebase valid/allowin handshake, an optional same-cycle bypass mode, and flush on exception/eret.
- Decouples ID from EX stalls: multiply/divide and memory wait cycles no longer back-pressure decode immediately.

Parameters:
- DEPTH, 2, number of buffered entries; legal values 1..8.
- PAYLOAD_WIDTH, $bits(id_to_ex_bus_t), width of the carried bus. The valid bit is taken from the handshake, not from the payload.
- BYPASS, 0, when 1 an entry arriving while the buffer is empty and EX allows in is forwarded combinationally that cycle.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- flush  input  1  exception/eret flush from WB; discards all held and incoming entries.
- id_to_ex_valid  input  1  ID presents a payload.
- id_to_ex_bus  input  PAYLOAD_WIDTH  ID payload.
- ex_allowin_to_id  output  1  buffer can accept this cycle.
- ex_valid_out  output  1  head entry valid toward EX.
- ex_bus_out  output  PAYLOAD_WIDTH  head payload.
- ex_allowin  input  1  EX accepts the head this cycle.
- occupancy  output  $clog2(DEPTH+1)  number of held entries.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.

Behaviour:
- Reset: when reset_n=0 at a clock edge:
  - read pointer, write pointer and occupancy clear to 0.
  - ex_valid_out=0, empty=1, full=0, ex_allowin_to_id=1 (with reset_n low; until the first edge it reflects pre-reset state).
  - ex_bus_out is don't-care. Payload storage is not cleared.
- Push: push = id_to_ex_valid & ex_allowin_to_id & ~flush.
- Pop: pop = ex_valid_out & ex_allowin & ~flush.
- Allowin: ex_allowin_to_id = ~full | ex_allowin. A full buffer accepts a push when it pops in the same cycle.
- BYPASS=0:
  - Head is registered. Latency is 1 cycle: data pushed at edge N appears on ex_bus_out after edge N.
  - ex_valid_out = ~empty.
- BYPASS=1 while empty:
  - ex_valid_out = id_to_ex_valid & ~flush.
  - ex_bus_out = id_to_ex_bus.
  - If ex_allowin=1, the entry is consumed without being stored and occupancy stays 0.
  - Otherwise it is stored.
- Pointer arithmetic:
  - Pointers are $clog2(DEPTH) bits and wrap explicitly at DEPTH-1 to 0, so non-power-of-2 DEPTH is supported. DEPTH=1 uses a 0-width-safe pointer (tied to 0).
  - occupancy_next = occupancy + push - pop (0-extended).
  - Simultaneous push and pop leaves occupancy unchanged. Both pointers advance.
- Flush:
  - Synchronous. At the edge, occupancy, read pointer and write pointer become 0.
  - Same-cycle push and pop are suppressed. In BYPASS mode ex_valid_out is also forced to 0 combinationally that cycle.
  - Flush wins over every other event.
- Ordering: strict FIFO. Entries are never reordered or duplicated.
- Protocol violation: a push attempt while full with ex_allowin=0 is blocked by allowin. If ID drives valid anyway, it is ignored and no storage is overwritten.
- Reset or flush mid-stall: the buffer becomes empty on the next edge. ID must hold or drop its payload per its own flush logic.
- No combinational path from ex_allowin to ex_bus_out. The only such path from id_to_ex_* to ex_* outputs is the BYPASS=1 empty case.

Decomposition:
- Shared package id_stage_params:
  - keeps id_to_ex_bus_t.
  - adds localparam ID_TO_EX_BUS_WIDTH = $bits(id_to_ex_bus_t).
  - adds an occupancy typedef helper function clog2_depth.
- One natural sub-module: issue_buffer_ram, a DEPTH x PAYLOAD_WIDTH register array with one write port and one asynchronous read port.
- Pointer, occupancy and handshake logic stay in id_ex_issue_buffer.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with id_to_ex_valid=1 -> ex_valid_out=0, occupancy=0, empty=1, ex_allowin_to_id=1 after reset.
- Stall fill (DEPTH=2, BYPASS=0): ex_allowin=0, push A then B -> occupancy 1 then 2, full=1, ex_allowin_to_id=0, head=A. Third payload C is not accepted.
- Full with concurrent pop: full, ex_allowin=1, push C -> pop A and push C in the same edge, occupancy stays 2. Heads seen thereafter are B then C.
- Flush priority: occupancy=2, assert flush with id_to_ex_valid=1 and ex_allowin=1 -> next cycle occupancy=0, ex_valid_out=0, pushed payload is absent.
- Bypass (BYPASS=1): empty, push 0xBFC00380-PC payload with ex_allowin=1 -> ex_valid_out=1 and ex_bus_out equals the input the same cycle, occupancy stays 0. Repeat with ex_allowin=0 -> stored, occupancy=1.
- Wrap (DEPTH=3): stream 10 payloads with randomised ex_allowin -> output order exactly matches input order, and pointers wrap 2->0 without loss.

Source files
------------

// File: rtl/id_ex_issue_buffer_pkg.sv
// Shared ID-stage definitions: the ID-to-EX payload layout and sizing helpers
// used by the issue buffer, its interface and its storage.
package id_stage_params;

  // Payload carried from decode to execute. The valid bit travels on the
  // handshake, not inside this struct.
  typedef struct packed {
    logic [11:0] alu_op;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        res_from_mem;
    logic        mem_we;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;
    logic [31:0] pc;
  } id_to_ex_bus_t;

  localparam int ID_TO_EX_BUS_WIDTH = $bits(id_to_ex_bus_t);

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int clog2_depth(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer indexing depth entries; a single entry still gets one
  // bit so the signal is never zero-width (it is simply tied to 0).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/id_ex_issue_buffer_if.sv
// ID/EX handshake bundle. "master" is the pipeline side (ID producer plus EX
// consumer); "slave" is the issue buffer sitting between them.
interface id_ex_issue_buffer_if
  import id_stage_params::*;
#(
  parameter int W = ID_TO_EX_BUS_WIDTH
) ();

  logic         id_to_ex_valid;
  logic [W-1:0] id_to_ex_bus;
  logic         ex_allowin_to_id;
  logic         ex_valid_out;
  logic [W-1:0] ex_bus_out;
  logic         ex_allowin;

  modport master (
    output id_to_ex_valid,
    output id_to_ex_bus,
    output ex_allowin,
    input  ex_allowin_to_id,
    input  ex_valid_out,
    input  ex_bus_out
  );

  modport slave (
    input  id_to_ex_valid,
    input  id_to_ex_bus,
    input  ex_allowin,
    output ex_allowin_to_id,
    output ex_valid_out,
    output ex_bus_out
  );

endinterface

// File: rtl/id_ex_issue_buffer_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module issue_buffer_ram #(
  parameter int DEPTH  = 2,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 1
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Each entry captures the write data only when it is the addressed slot.
    always_ff @(posedge clock) begin
      if (we && (waddr == ADDR_W'(gi))) begin
        mem_q[gi] <= wdata;
      end
    end
  end

  // Head is read combinationally from the registered array, so it only
  // changes after a clock edge.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/id_ex_issue_buffer.sv
// Elastic ID->EX issue buffer: a DEPTH-entry FIFO speaking the valid/allowin
// handshake on both sides, with optional empty-buffer bypass and a flush that
// discards everything held or arriving.
module id_ex_issue_buffer
  import id_stage_params::*;
#(
  parameter int DEPTH         = 2,
  parameter int PAYLOAD_WIDTH = ID_TO_EX_BUS_WIDTH,
  parameter int BYPASS        = 0,
  localparam int OCC_W        = clog2_depth(DEPTH),
  localparam int PTR_W        = ptr_width(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  id_ex_issue_buffer_if.slave  bus,
  output logic [OCC_W-1:0]     occupancy,
  output logic                 full,
  output logic                 empty
);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [OCC_W-1:0]         occ_q, occ_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_inc, wr_ptr_inc;
  logic [PAYLOAD_WIDTH-1:0] ram_rdata;

  logic is_empty, is_full;
  logic bypass_active;
  logic allowin, head_valid;
  logic [PAYLOAD_WIDTH-1:0] head_bus;
  logic push, pop;
  logic store;   // push that actually lands in storage
  logic drain;   // pop that actually removes a stored entry

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  if (DEPTH > 1) begin : g_ptr_wrap
    assign rd_ptr_inc = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    assign wr_ptr_inc = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
  end else begin : g_ptr_single
    assign rd_ptr_inc = '0;
    assign wr_ptr_inc = '0;
  end

  // Handshake: allowin, head selection (bypass vs storage), push/pop decode.
  always_comb begin
    is_empty      = (occ_q == '0);
    is_full       = (occ_q == OCC_FULL);
    bypass_active = (BYPASS != 0) && is_empty;

    // A full buffer can still take a push when the head leaves this cycle.
    allowin = ~is_full | bus.ex_allowin;

    if (bypass_active) begin
      head_valid = bus.id_to_ex_valid & ~flush;
      head_bus   = bus.id_to_ex_bus;
    end else begin
      head_valid = ~is_empty;
      head_bus   = ram_rdata;
    end

    push = bus.id_to_ex_valid & allowin & ~flush;
    pop  = head_valid & bus.ex_allowin & ~flush;

    // In bypass, an entry taken by EX in its arrival cycle never touches
    // storage; otherwise pushes write and pops read the array.
    store = push & ~(bypass_active & pop);
    drain = pop & ~bypass_active;
  end

  // Next-state for pointers and occupancy; flush overrides every other event.
  always_comb begin
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      occ_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (store) wr_ptr_d = wr_ptr_inc;
      if (drain) rd_ptr_d = rd_ptr_inc;
      occ_d = occ_q + OCC_W'(store) - OCC_W'(drain);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      occ_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  issue_buffer_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (PAYLOAD_WIDTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clock (clock),
    .we    (store),
    .waddr (wr_ptr_q),
    .wdata (bus.id_to_ex_bus),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign bus.ex_allowin_to_id = allowin;
  assign bus.ex_valid_out     = head_valid;
  assign bus.ex_bus_out       = head_bus;
  assign occupancy            = occ_q;
  assign full                 = is_full;
  assign empty                = is_empty;

endmodule

// File: tb/tb_id_ex_issue_buffer.sv
// Self-checking bench for id_ex_issue_buffer. Three instances cover the
// registered DEPTH=2 buffer, the DEPTH=2 bypass buffer and a DEPTH=3 buffer
// for pointer wrap. A per-instance reference queue receives every accepted
// payload and is popped whenever EX takes the head.
module tb_id_ex_issue_buffer;
  import id_stage_params::*;

  localparam int W = ID_TO_EX_BUS_WIDTH;

  logic clock = 1'b0;
  logic reset_n;
  logic flush_a, flush_b, flush_c;
  logic [1:0] occ_a, occ_b, occ_c;
  logic full_a, full_b, full_c;
  logic empty_a, empty_b, empty_c;

  always #5 clock = ~clock;

  id_ex_issue_buffer_if #(.W(W)) if_a ();
  id_ex_issue_buffer_if #(.W(W)) if_b ();
  id_ex_issue_buffer_if #(.W(W)) if_c ();

  id_ex_issue_buffer #(.DEPTH(2), .PAYLOAD_WIDTH(W), .BYPASS(0)) u_d2 (
    .clock(clock), .reset_n(reset_n), .flush(flush_a), .bus(if_a),
    .occupancy(occ_a), .full(full_a), .empty(empty_a));

  id_ex_issue_buffer #(.DEPTH(2), .PAYLOAD_WIDTH(W), .BYPASS(1)) u_byp (
    .clock(clock), .reset_n(reset_n), .flush(flush_b), .bus(if_b),
    .occupancy(occ_b), .full(full_b), .empty(empty_b));

  id_ex_issue_buffer #(.DEPTH(3), .PAYLOAD_WIDTH(W), .BYPASS(0)) u_d3 (
    .clock(clock), .reset_n(reset_n), .flush(flush_c), .bus(if_c),
    .occupancy(occ_c), .full(full_c), .empty(empty_c));

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, indexed 0=d2, 1=byp, 2=d3.
  int            depth_m [3] = '{2, 2, 3};
  bit            byp_m   [3] = '{1'b0, 1'b1, 1'b0};
  int            occ_m   [3];
  int            pushed_m[3];
  int            popped_m[3];
  logic [W-1:0]  exp_q   [3][$];

  function automatic logic [W-1:0] mk(input logic [31:0] pc);
    id_to_ex_bus_t p;
    p           = '0;
    p.pc        = pc;
    p.imm       = ~pc;
    p.rj_value  = pc ^ 32'h5A5A_0F0F;
    p.rkd_value = {pc[15:0], pc[31:16]};
    p.dest      = pc[6:2];
    p.alu_op    = pc[13:2];
    p.rf_we     = pc[2];
    return p;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare one instance against the model for the current cycle, then
  // advance the model as the coming clock edge will.
  task automatic sb_step(input int k, input string nm,
                         input logic v, input logic [W-1:0] b, input logic ea, input logic fl,
                         input logic o_allow, input logic o_valid, input logic [W-1:0] o_bus,
                         input int o_occ, input logic o_full, input logic o_empty);
    bit m_full, m_empty, m_allow, m_valid, m_push, m_pop;
    m_full  = (occ_m[k] == depth_m[k]);
    m_empty = (occ_m[k] == 0);
    m_allow = !m_full || ea;
    m_valid = (byp_m[k] && m_empty) ? (v && !fl) : !m_empty;
    m_push  = v && m_allow && !fl;
    m_pop   = m_valid && ea && !fl;

    check({nm, ":occupancy"}, 256'(o_occ), 256'(occ_m[k]));
    check({nm, ":full"},      256'(o_full), 256'(m_full));
    check({nm, ":empty"},     256'(o_empty), 256'(m_empty));
    check({nm, ":allowin"},   256'(o_allow), 256'(m_allow));
    check({nm, ":valid"},     256'(o_valid), 256'(m_valid));

    if (m_push) begin
      exp_q[k].push_back(b);
      pushed_m[k]++;
    end
    if (m_valid) begin
      if (exp_q[k].size() == 0) begin
        check({nm, ":sb_underflow"}, 256'(0), 256'(1));
      end else begin
        check({nm, ":head"}, 256'(o_bus), 256'(exp_q[k][0]));
      end
    end
    if (m_pop && exp_q[k].size() != 0) begin
      void'(exp_q[k].pop_front());
      popped_m[k]++;
    end
    if (fl) begin
      exp_q[k].delete();
      occ_m[k] = 0;
    end else begin
      occ_m[k] = occ_m[k] + int'(m_push) - int'(m_pop);
    end
  endtask

  // One clock cycle: sample mid-cycle, then let the edge happen.
  task automatic tick();
    @(negedge clock);
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) begin
        occ_m[k] = 0;
        exp_q[k].delete();
      end
    end else begin
      sb_step(0, "d2", if_a.id_to_ex_valid, if_a.id_to_ex_bus, if_a.ex_allowin, flush_a,
              if_a.ex_allowin_to_id, if_a.ex_valid_out, if_a.ex_bus_out, int'(occ_a), full_a, empty_a);
      sb_step(1, "byp", if_b.id_to_ex_valid, if_b.id_to_ex_bus, if_b.ex_allowin, flush_b,
              if_b.ex_allowin_to_id, if_b.ex_valid_out, if_b.ex_bus_out, int'(occ_b), full_b, empty_b);
      sb_step(2, "d3", if_c.id_to_ex_valid, if_c.id_to_ex_bus, if_c.ex_allowin, flush_c,
              if_c.ex_allowin_to_id, if_c.ex_valid_out, if_c.ex_bus_out, int'(occ_c), full_c, empty_c);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset held for 3 cycles with ID presenting data on every instance.
    reset_n = 1'b0;
    flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
    if_a.id_to_ex_valid = 1'b1; if_a.id_to_ex_bus = mk(32'h0000_0100); if_a.ex_allowin = 1'b0;
    if_b.id_to_ex_valid = 1'b1; if_b.id_to_ex_bus = mk(32'h0000_0200); if_b.ex_allowin = 1'b0;
    if_c.id_to_ex_valid = 1'b1; if_c.id_to_ex_bus = mk(32'h0000_0300); if_c.ex_allowin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      occ_m[k] = 0; pushed_m[k] = 0; popped_m[k] = 0;
    end
    repeat (3) tick();
    reset_n = 1'b1;
    if_a.id_to_ex_valid = 1'b0; if_b.id_to_ex_valid = 1'b0; if_c.id_to_ex_valid = 1'b0;
    tick();   // post-reset state: empty, not valid, allowin high

    // Stall fill on d2: A, B accepted; C refused while full and stalled.
    if_a.ex_allowin = 1'b0;
    if_a.id_to_ex_valid = 1'b1; if_a.id_to_ex_bus = mk(32'h0000_A000); tick();
    if_a.id_to_ex_bus = mk(32'h0000_B000); tick();
    if_a.id_to_ex_bus = mk(32'h0000_C000); tick();
    tick();
    // Full with concurrent pop: A leaves, C enters on the same edge.
    if_a.ex_allowin = 1'b1; tick();
    if_a.id_to_ex_valid = 1'b0; if_a.ex_allowin = 1'b0; tick();
    if_a.ex_allowin = 1'b1; tick();
    tick();
    if_a.ex_allowin = 1'b0; tick();

    // Flush priority: fill with D, E, then flush while F is offered.
    if_a.id_to_ex_valid = 1'b1; if_a.id_to_ex_bus = mk(32'h0000_D000); tick();
    if_a.id_to_ex_bus = mk(32'h0000_E000); tick();
    flush_a = 1'b1; if_a.ex_allowin = 1'b1; if_a.id_to_ex_bus = mk(32'h0000_F000); tick();
    flush_a = 1'b0; if_a.id_to_ex_valid = 1'b0; if_a.ex_allowin = 1'b0; tick();
    if_a.id_to_ex_valid = 1'b1; if_a.id_to_ex_bus = mk(32'h0000_6000); tick();
    if_a.id_to_ex_valid = 1'b0; tick();
    if_a.ex_allowin = 1'b1; tick();
    if_a.ex_allowin = 1'b0; tick();

    // Bypass: consumed in the arrival cycle, then stored when EX stalls.
    if_b.ex_allowin = 1'b1;
    if_b.id_to_ex_valid = 1'b1; if_b.id_to_ex_bus = mk(32'hBFC0_0380); tick();
    if_b.ex_allowin = 1'b0; if_b.id_to_ex_bus = mk(32'hBFC0_0384); tick();
    if_b.id_to_ex_bus = mk(32'hBFC0_0388); tick();
    if_b.id_to_ex_valid = 1'b0; if_b.ex_allowin = 1'b1; tick();
    tick();
    tick();
    // Bypass flush: an arriving entry must not appear valid.
    flush_b = 1'b1; if_b.id_to_ex_valid = 1'b1; if_b.id_to_ex_bus = mk(32'hBFC0_0400); tick();
    flush_b = 1'b0; if_b.id_to_ex_valid = 1'b0; if_b.ex_allowin = 1'b0; tick();

    // Wrap on d3: stream 10 payloads with random EX stalls.
    for (int cyc = 0; cyc < 200 && pushed_m[2] < 10; cyc++) begin
      if_c.id_to_ex_valid = 1'b1;
      if_c.id_to_ex_bus   = mk(32'h0000_1000 + 32'(pushed_m[2]) * 32'd4);
      if_c.ex_allowin     = 1'($urandom_range(0, 1));
      tick();
    end
    check("d3:all_pushed", 256'(pushed_m[2]), 256'(10));
    if_c.id_to_ex_valid = 1'b0; if_c.ex_allowin = 1'b1;
    for (int cyc = 0; cyc < 20 && occ_m[2] != 0; cyc++) begin
      tick();
    end
    tick();
    check("d3:all_popped", 256'(popped_m[2]), 256'(10));
    check("d3:sb_drained", 256'(exp_q[2].size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
